pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing unit for the 5-stage MIPS pipeline. Drives the EN/CLR/bb controls of the IFtoID, IDtoEX, EXtoMEM and MEMtoWB pipeline registers and the PC write-enable.
- Resolves load-use stalls, taken branch/jump/ERET redirects, multi-cycle HI/LO (mult/div) occupancy, interrupt entry and SYSCALL halt.
- Sits beside the decoder and takes hazard inputs from the ID, EX and WB stages.

Parameters:
MD_LAT, 4, mult/div occupancy in cycles, including the issue cycle (range 2..15)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
id_rs  in  5  ID-stage rs number
id_rt  in  5  ID-stage rt number
id_rs_used  in  1  ID instruction reads rs
id_rt_used  in  1  ID instruction reads rt
ex_MemtoReg  in  1  EX instruction is a load
ex_RegWrite  in  1  EX instruction writes the GPR file
ex_WbRegNum  in  5  EX destination register
ex_redirect  in  1  EX branch taken, or J/JAL
ex_ERET  in  1  EX instruction is ERET
ex_muldiv  in  1  EX instruction is mult/div (HIWrite&LOWrite)
wb_SYSCALL  in  1  WB instruction is SYSCALL
irq  in  1  level interrupt request
go  in  1  resume pulse from halt
PC_EN  out  1  PC write enable
pc_sel  out  2  0 = seq, 1 = branch/jump target, 2 = exception vector, 3 = EPC
IFtoID_EN, IFtoID_CLR  out  1,1
IDtoEX_EN, IDtoEX_CLR  out  1,1
EXtoMEM_EN, EXtoMEM_CLR  out  1,1
MEMtoWB_EN, MEMtoWB_CLR  out  1,1
exc_take  out  1  one-cycle pulse: save EPC, write CP0 cause
halted  out  1  high while in HALT
stall_cnt  out  CNT_W  cycles with PC_EN=0 outside HALT
flush_cnt  out  CNT_W  redirect plus exception events

Behaviour:
- **FSM states:** RUN, MD_WAIT, EXC, HALT. On reset: RUN, md_cnt=0, irq_pend=0, counters=0.
- **Outputs during rst=1:** all *_EN=0, all *_CLR=1, pc_sel=0, exc_take=0, halted=0.
- **Defaults in RUN:** all EN=1, all CLR=0, pc_sel=0.
- **irq_pend:** set on irq=1 in any state. Cleared on the cycle exc_take=1.
- **Priority within a cycle:** HALT entry > EXC entry > MD_WAIT entry > redirect/ERET > load-use.
- **HALT entry:** wb_SYSCALL=1 in RUN or MD_WAIT → next state HALT.
  - In the entry cycle, MEMtoWB_CLR=1 and everything else is frozen (EN=0).
  - In HALT: all EN=0, halted=1.
  - go=1 → RUN next cycle. The SYSCALL has already retired; the pipeline resumes from the frozen contents.
- **EXC entry:** in RUN with irq_pend=1 and no higher-priority event → state EXC for exactly one cycle.
  - In EXC: exc_take=1, pc_sel=2, PC_EN=1, IFtoID_CLR=IDtoEX_CLR=EXtoMEM_CLR=1, MEMtoWB_EN=1, flush_cnt+1.
  - Next state RUN.
- **MD_WAIT entry:** ex_muldiv=1 in RUN → md_cnt loads MD_LAT-1. The issue cycle itself is normal (EN=1).
  - In MD_WAIT: PC_EN=IFtoID_EN=IDtoEX_EN=EXtoMEM_EN=0 and EXtoMEM_CLR=1, so bubbles drain downstream. MEMtoWB_EN=1.
  - md_cnt decrements each cycle. At md_cnt==1 → RUN. Total freeze is MD_LAT-1 cycles.
  - irq during MD_WAIT is deferred via irq_pend.
- **Redirect:** ex_redirect=1 or ex_ERET=1 in RUN (combinational).
  - pc_sel=1 (ERET: 3), PC_EN=1, IFtoID_CLR=1, IDtoEX_CLR=1, flush_cnt+1.
  - The load-use condition is ignored in that cycle.
- **Load-use:** ex_MemtoReg & ex_RegWrite & ex_WbRegNum≠0 & ((id_rs_used & id_rs==ex_WbRegNum) | (id_rt_used & id_rt==ex_WbRegNum)).
  - Response: PC_EN=0, IFtoID_EN=0, IDtoEX_CLR=1 (bubble). Lasts exactly one cycle because the bubble removes the condition.
- **Register 0:** writes to $0 never cause a stall.
- **stall_cnt:** increments on every cycle with PC_EN=0 and state≠HALT, and not while rst=1. Both counters wrap modulo 2^CNT_W.
- **Mid-operation reset:** rst asserted mid-MD_WAIT or HALT returns to RUN next cycle with all state cleared.

Decomposition:
- Shared package: FSM state encoding (2-bit) and pc_sel constants (PC_SEQ, PC_BR, PC_EXC, PC_EPC).
- Sub-module: hazard_detect, the purely combinational load-use comparator. All other logic stays in the top module.

Test Plan:
- **Load-use:** EX lw $8, ID add $9,$8,$1 → one cycle PC_EN=0, IFtoID_EN=0, IDtoEX_CLR=1, stall_cnt=1. Same case with ex_WbRegNum=0 → no stall.
- **Redirect vs load-use:** ex_redirect=1 and load-use true in the same cycle → pc_sel=1, IFtoID_CLR=IDtoEX_CLR=1, PC_EN=1, flush_cnt=1.
- **Mult/div freeze:** MD_LAT=4, ex_muldiv pulse → next 3 cycles PC_EN=0, EXtoMEM_CLR=1, MEMtoWB_EN=1; RUN on the 4th cycle. irq raised mid-wait → exc_take exactly one cycle after return to RUN, pc_sel=2.
- **Halt/resume:** wb_SYSCALL=1 → MEMtoWB_CLR=1 that cycle, then halted=1 with all EN=0 for 10 cycles, stall_cnt unchanged; go pulse → RUN, EN=1.
- **ERET:** ex_ERET=1 → pc_sel=3, IFtoID_CLR=IDtoEX_CLR=1 for one cycle.
- **Reset mid-wait:** rst during MD_WAIT → all CLR=1 while rst held; after release state RUN, counters 0, irq_pend 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared FSM encoding and PC select codes
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_EXC     = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_EXC = 2'd2;
  localparam logic [1:0] PC_EPC = 2'd3;

  // Wide enough for the largest supported mult/div occupancy (15).
  localparam int MD_CNT_W = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use comparator
module pipeline_hazard_ctrl_hazard_detect (
  input  logic       ex_mem_to_reg_i,
  input  logic       ex_reg_write_i,
  input  logic [4:0] ex_wb_reg_num_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_rs_used_i,
  input  logic       id_rt_used_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_used_i && (id_rs_i == ex_wb_reg_num_i);
  assign rt_hit = id_rt_used_i && (id_rt_i == ex_wb_reg_num_i);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use_o = ex_mem_to_reg_i && ex_reg_write_i &&
                      (ex_wb_reg_num_i != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline register / PC sequencing for the 5-stage MIPS core
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_MemtoReg,
  input  logic             ex_RegWrite,
  input  logic [4:0]       ex_WbRegNum,
  input  logic             ex_redirect,
  input  logic             ex_ERET,
  input  logic             ex_muldiv,
  input  logic             wb_SYSCALL,
  input  logic             irq,
  input  logic             go,
  output logic             PC_EN,
  output logic [1:0]       pc_sel,
  output logic             IFtoID_EN,
  output logic             IFtoID_CLR,
  output logic             IDtoEX_EN,
  output logic             IDtoEX_CLR,
  output logic             EXtoMEM_EN,
  output logic             EXtoMEM_CLR,
  output logic             MEMtoWB_EN,
  output logic             MEMtoWB_CLR,
  output logic             exc_take,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                irq_pend_q, irq_pend_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                load_use;
  logic                halt_entry;
  logic                flush_evt;

  pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
    .ex_mem_to_reg_i (ex_MemtoReg),
    .ex_reg_write_i  (ex_RegWrite),
    .ex_wb_reg_num_i (ex_WbRegNum),
    .id_rs_i         (id_rs),
    .id_rt_i         (id_rt),
    .id_rs_used_i    (id_rs_used),
    .id_rt_used_i    (id_rt_used),
    .load_use_o      (load_use)
  );

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    irq_pend_d  = irq_pend_q | irq;
    PC_EN       = 1'b1;
    IFtoID_EN   = 1'b1;
    IDtoEX_EN   = 1'b1;
    EXtoMEM_EN  = 1'b1;
    MEMtoWB_EN  = 1'b1;
    IFtoID_CLR  = 1'b0;
    IDtoEX_CLR  = 1'b0;
    EXtoMEM_CLR = 1'b0;
    MEMtoWB_CLR = 1'b0;
    pc_sel      = PC_SEQ;
    exc_take    = 1'b0;
    halted      = 1'b0;
    flush_evt   = 1'b0;
    halt_entry  = wb_SYSCALL && (state_q == ST_RUN || state_q == ST_MD_WAIT);

    // SYSCALL retires into WB while everything upstream stays frozen.
    if (halt_entry) begin
      {PC_EN, IFtoID_EN, IDtoEX_EN, EXtoMEM_EN, MEMtoWB_EN} = '0;
      MEMtoWB_CLR = 1'b1;
      md_cnt_d    = '0;
      state_d     = ST_HALT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (irq_pend_q) begin
            state_d = ST_EXC;
          end else if (ex_muldiv) begin
            md_cnt_d = MD_CNT_W'(MD_LAT - 1);
            state_d  = ST_MD_WAIT;
          end else if (ex_redirect || ex_ERET) begin
            pc_sel     = ex_ERET ? PC_EPC : PC_BR;
            IFtoID_CLR = 1'b1;
            IDtoEX_CLR = 1'b1;
            flush_evt  = 1'b1;
          end else if (load_use) begin
            PC_EN      = 1'b0;
            IFtoID_EN  = 1'b0;
            IDtoEX_CLR = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          {PC_EN, IFtoID_EN, IDtoEX_EN, EXtoMEM_EN} = '0;
          EXtoMEM_CLR = 1'b1;
          md_cnt_d    = md_cnt_q - MD_CNT_W'(1);
          if (md_cnt_q <= MD_CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        ST_EXC: begin
          exc_take    = 1'b1;
          pc_sel      = PC_EXC;
          IFtoID_CLR  = 1'b1;
          IDtoEX_CLR  = 1'b1;
          EXtoMEM_CLR = 1'b1;
          flush_evt   = 1'b1;
          irq_pend_d  = 1'b0;
          state_d     = ST_RUN;
        end
        default: begin
          {PC_EN, IFtoID_EN, IDtoEX_EN, EXtoMEM_EN, MEMtoWB_EN} = '0;
          halted = 1'b1;
          if (go) begin
            state_d = ST_RUN;
          end
        end
      endcase
    end

    if (rst) begin
      {PC_EN, IFtoID_EN, IDtoEX_EN, EXtoMEM_EN, MEMtoWB_EN} = '0;
      {IFtoID_CLR, IDtoEX_CLR, EXtoMEM_CLR, MEMtoWB_CLR}    = '1;
      pc_sel    = PC_SEQ;
      exc_take  = 1'b0;
      halted    = 1'b0;
      flush_evt = 1'b0;
    end
  end

  assign stall_cnt_d = stall_cnt_q + CNT_W'(!PC_EN && (state_q != ST_HALT));
  assign flush_cnt_d = flush_cnt_q + CNT_W'(flush_evt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= '0;
      irq_pend_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      irq_pend_q  <= irq_pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_WbRegNum;
  logic             id_rs_used, id_rt_used, ex_MemtoReg, ex_RegWrite;
  logic             ex_redirect, ex_ERET, ex_muldiv, wb_SYSCALL, irq, go;
  logic             PC_EN, IFtoID_EN, IFtoID_CLR, IDtoEX_EN, IDtoEX_CLR;
  logic             EXtoMEM_EN, EXtoMEM_CLR, MEMtoWB_EN, MEMtoWB_CLR;
  logic             exc_take, halted;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite), .ex_WbRegNum(ex_WbRegNum),
    .ex_redirect(ex_redirect), .ex_ERET(ex_ERET), .ex_muldiv(ex_muldiv),
    .wb_SYSCALL(wb_SYSCALL), .irq(irq), .go(go),
    .PC_EN(PC_EN), .pc_sel(pc_sel),
    .IFtoID_EN(IFtoID_EN), .IFtoID_CLR(IFtoID_CLR),
    .IDtoEX_EN(IDtoEX_EN), .IDtoEX_CLR(IDtoEX_CLR),
    .EXtoMEM_EN(EXtoMEM_EN), .EXtoMEM_CLR(EXtoMEM_CLR),
    .MEMtoWB_EN(MEMtoWB_EN), .MEMtoWB_CLR(MEMtoWB_CLR),
    .exc_take(exc_take), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: halted flag, pending exception cycle, remaining freeze cycles, pending irq.
  bit               m_halted = 1'b0;
  bit               m_exc = 1'b0;
  bit               m_pend = 1'b0;
  int               m_freeze = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  always @(negedge clk) begin
    logic [3:0]  en, clr;
    logic [1:0]  ps;
    logic        pe, et, hl, lu, fl;
    logic [12:0] act_v, exp_v;
    bit          n_halted, n_exc, n_pend;
    int          n_freeze;

    lu = ex_MemtoReg && ex_RegWrite && (ex_WbRegNum != 5'd0) &&
         ((id_rs_used && id_rs == ex_WbRegNum) || (id_rt_used && id_rt == ex_WbRegNum));
    pe = 1'b1; ps = 2'd0; en = 4'b1111; clr = 4'b0000; et = 1'b0; hl = 1'b0; fl = 1'b0;
    n_halted = m_halted; n_exc = 1'b0; n_freeze = m_freeze; n_pend = m_pend || irq;

    if (rst) begin
      pe = 1'b0; en = 4'b0000; clr = 4'b1111;
      n_halted = 1'b0; n_freeze = 0; n_pend = 1'b0;
    end else if (m_halted) begin
      pe = 1'b0; en = 4'b0000; hl = 1'b1; n_halted = !go;
    end else if (m_exc) begin
      et = 1'b1; ps = 2'd2; clr = 4'b1110; n_pend = 1'b0; fl = 1'b1;
    end else if (wb_SYSCALL) begin
      pe = 1'b0; en = 4'b0000; clr = 4'b0001; n_halted = 1'b1; n_freeze = 0;
    end else if (m_freeze > 0) begin
      pe = 1'b0; en = 4'b0001; clr = 4'b0010; n_freeze = m_freeze - 1;
    end else if (m_pend) begin
      n_exc = 1'b1;
    end else if (ex_muldiv) begin
      n_freeze = MD_LAT - 1;
    end else if (ex_redirect || ex_ERET) begin
      ps = ex_ERET ? 2'd3 : 2'd1; clr = 4'b1100; fl = 1'b1;
    end else if (lu) begin
      pe = 1'b0; en = 4'b0111; clr = 4'b0100;
    end

    act_v = {PC_EN, pc_sel, IFtoID_EN, IDtoEX_EN, EXtoMEM_EN, MEMtoWB_EN,
             IFtoID_CLR, IDtoEX_CLR, EXtoMEM_CLR, MEMtoWB_CLR, exc_take, halted};
    exp_v = {pe, ps, en, clr, et, hl};
    chk("ctrl_vector", 64'(act_v), 64'(exp_v));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));

    if (rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!pe && !m_halted) m_stall = m_stall + 1'b1;
      if (fl) m_flush = m_flush + 1'b1;
    end
    m_halted = n_halted; m_exc = n_exc; m_pend = n_pend; m_freeze = n_freeze;
  end

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    ex_MemtoReg = 1'b0; ex_RegWrite = 1'b0; ex_WbRegNum = 5'd0;
    ex_redirect = 1'b0; ex_ERET = 1'b0; ex_muldiv = 1'b0;
    wb_SYSCALL = 1'b0; irq = 1'b0; go = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] dst, input logic [4:0] rs, input logic rs_u,
                      input logic [4:0] rt, input logic rt_u);
    ex_MemtoReg = 1'b1; ex_RegWrite = 1'b1; ex_WbRegNum = dst;
    id_rs = rs; id_rs_used = rs_u; id_rt = rt; id_rt_used = rt_u;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mid();
    chk("rst_PC_EN", 64'(PC_EN), 64'd0);
    chk("rst_MEMtoWB_CLR", 64'(MEMtoWB_CLR), 64'd1);
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // lw $8 in EX, add $9,$8,$1 in ID
    load(5'd8, 5'd8, 1'b1, 5'd1, 1'b1);
    mid();
    chk("lu_PC_EN", 64'(PC_EN), 64'd0);
    chk("lu_IFtoID_EN", 64'(IFtoID_EN), 64'd0);
    chk("lu_IDtoEX_CLR", 64'(IDtoEX_CLR), 64'd1);
    step();
    idle();
    mid();
    chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    step();
    load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    mid();
    chk("lu_r0_PC_EN", 64'(PC_EN), 64'd1);
    step();
    load(5'd8, 5'd3, 1'b1, 5'd8, 1'b1);
    step();
    load(5'd8, 5'd8, 1'b0, 5'd2, 1'b1);
    step();

    // Redirect outranks a simultaneous load-use
    load(5'd8, 5'd8, 1'b1, 5'd1, 1'b1);
    ex_redirect = 1'b1;
    mid();
    chk("br_pc_sel", 64'(pc_sel), 64'd1);
    chk("br_PC_EN", 64'(PC_EN), 64'd1);
    chk("br_IFtoID_CLR", 64'(IFtoID_CLR), 64'd1);
    step();
    idle();
    mid();
    chk("br_flush_cnt", 64'(flush_cnt), 64'd1);
    step();
    ex_ERET = 1'b1;
    mid();
    chk("eret_pc_sel", 64'(pc_sel), 64'd3);
    chk("eret_IDtoEX_CLR", 64'(IDtoEX_CLR), 64'd1);
    step();
    idle();

    // mult/div freeze with irq arriving mid-wait
    ex_muldiv = 1'b1;
    mid();
    chk("md_issue_PC_EN", 64'(PC_EN), 64'd1);
    step();
    idle();
    for (int w = 0; w < MD_LAT - 1; w++) begin
      irq = (w == 1);
      mid();
      chk("md_wait_PC_EN", 64'(PC_EN), 64'd0);
      chk("md_wait_EXtoMEM_CLR", 64'(EXtoMEM_CLR), 64'd1);
      chk("md_wait_MEMtoWB_EN", 64'(MEMtoWB_EN), 64'd1);
      step();
    end
    irq = 1'b0;
    mid();
    chk("md_run_PC_EN", 64'(PC_EN), 64'd1);
    chk("md_run_exc_take", 64'(exc_take), 64'd0);
    step();
    mid();
    chk("exc_take", 64'(exc_take), 64'd1);
    chk("exc_pc_sel", 64'(pc_sel), 64'd2);
    step();
    mid();
    chk("exc_once", 64'(exc_take), 64'd0);
    chk("exc_stall_cnt", 64'(stall_cnt), 64'd5);
    chk("exc_flush_cnt", 64'(flush_cnt), 64'd3);
    step();

    // SYSCALL halt and resume
    wb_SYSCALL = 1'b1;
    mid();
    chk("halt_entry_MEMtoWB_CLR", 64'(MEMtoWB_CLR), 64'd1);
    chk("halt_entry_MEMtoWB_EN", 64'(MEMtoWB_EN), 64'd0);
    step();
    wb_SYSCALL = 1'b0;
    for (int h = 0; h < 10; h++) begin
      if (h == 4) ex_redirect = 1'b1;
      mid();
      chk("halt_halted", 64'(halted), 64'd1);
      chk("halt_IFtoID_EN", 64'(IFtoID_EN), 64'd0);
      step();
      ex_redirect = 1'b0;
    end
    go = 1'b1;
    step();
    go = 1'b0;
    mid();
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_PC_EN", 64'(PC_EN), 64'd1);
    chk("resume_stall_cnt", 64'(stall_cnt), 64'd6);
    step();

    // SYSCALL while frozen for mult/div, irq held across halt
    ex_muldiv = 1'b1;
    step();
    idle();
    wb_SYSCALL = 1'b1;
    step();
    wb_SYSCALL = 1'b0;
    irq = 1'b1;
    step();
    irq = 1'b0;
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    step();

    // Pending irq outranks a redirect in the same cycle
    irq = 1'b1;
    step();
    irq = 1'b0;
    ex_redirect = 1'b1;
    mid();
    chk("irq_vs_br_pc_sel", 64'(pc_sel), 64'd0);
    step();
    ex_redirect = 1'b0;
    mid();
    chk("irq_vs_br_exc_take", 64'(exc_take), 64'd1);
    step();

    // Reset in the middle of a mult/div wait with an irq pending
    ex_muldiv = 1'b1;
    step();
    idle();
    irq = 1'b1;
    step();
    irq = 1'b0;
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      mid();
      chk("rst_mid_IFtoID_CLR", 64'(IFtoID_CLR), 64'd1);
      chk("rst_mid_EXtoMEM_CLR", 64'(EXtoMEM_CLR), 64'd1);
      chk("rst_mid_PC_EN", 64'(PC_EN), 64'd0);
      step();
    end
    rst = 1'b0;
    mid();
    chk("post_rst_PC_EN", 64'(PC_EN), 64'd1);
    chk("post_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("post_rst_flush_cnt", 64'(flush_cnt), 64'd0);
    step();
    mid();
    chk("post_rst_no_exc", 64'(exc_take), 64'd0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
